// File: rtl/spartan_reg_slave.sv
// spartan_reg_slave
// Spartan-bus responder in front of a bank of NREGS read/write registers.
// Request beats arrive on SpMBUS/SpMVLD/SpMRDY and response beats leave on
// SpSBUS/SpSVLD/SpSRDY. Every output comes straight from a flop.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | ready for a read or write header; stray beats are dropped
// WDATA   | write header taken, waiting for the WR_DATA beat
// RSP_HDR | presenting RSP_OK / RSP_ERR carrying the request tag
// RSP_DAT | presenting RSP_DATA for a good read (captured on entry)

module spartan_reg_slave #(
    parameter int BWIDTH   = 64,
    parameter int NREGS    = 16,
    parameter int ADDR_LSB = 3
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [BWIDTH+1:0]         SpMBUS,
    input  logic                      SpMVLD,
    output logic                      SpMRDY,
    output logic [BWIDTH+1:0]         SpSBUS,
    output logic                      SpSVLD,
    input  logic                      SpSRDY,
    output logic [NREGS*BWIDTH-1:0]   REG_OUT,
    output logic [NREGS-1:0]          WR_PULSE
);

    localparam int BUSW = BWIDTH + 2;
    localparam int IDXW = $clog2(NREGS);

    // Byte-offset bits that must be zero, and the first byte address past the bank.
    localparam logic [31:0] ALIGN_MASK = (32'd1 << ADDR_LSB) - 32'd1;
    localparam logic [32:0] ADDR_LIMIT = 33'(NREGS) << ADDR_LSB;

    localparam logic [1:0] TYP_RD_HDR  = 2'b01;
    localparam logic [1:0] TYP_WR_HDR  = 2'b10;
    localparam logic [1:0] TYP_WR_DATA = 2'b11;

    localparam logic [1:0] RSP_OK   = 2'b01;
    localparam logic [1:0] RSP_ERR  = 2'b10;
    localparam logic [1:0] RSP_DATA = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WDATA   = 2'd1,
        RSP_HDR = 2'd2,
        RSP_DAT = 2'd3
    } stateT;

    stateT state;
    stateT stateNext;

    // Transaction context captured from the header beat.
    logic [7:0]      tagQ;
    logic [7:0]      tagNext;
    logic [IDXW-1:0] idxQ;
    logic [IDXW-1:0] idxNext;
    logic            errQ;
    logic            errNext;
    logic            rdQ;
    logic            rdNext;

    logic            mRdyNext;
    logic            sVldNext;
    logic [BUSW-1:0] sBusNext;
    logic            wrEn;
    logic [NREGS-1:0] pulseNext;

    logic [BWIDTH-1:0] regs [NREGS];

    logic            reqFire;
    logic            rspFire;
    logic [1:0]      reqType;
    logic [7:0]      reqTag;
    logic [31:0]     reqAddr;
    logic [IDXW-1:0] reqIdx;
    logic            reqBad;

    assign reqFire = SpMVLD & SpMRDY;
    assign rspFire = SpSVLD & SpSRDY;
    assign reqType = SpMBUS[BUSW-1:BWIDTH];
    assign reqTag  = SpMBUS[39:32];
    assign reqAddr = SpMBUS[31:0];
    assign reqIdx  = reqAddr[ADDR_LSB +: IDXW];
    assign reqBad  = ((reqAddr & ALIGN_MASK) != 32'd0) || ({1'b0, reqAddr} >= ADDR_LIMIT);

    // Status beat: type on top, tag in [39:32], everything else zero.
    function automatic logic [BUSW-1:0] mkRsp(input logic [1:0] typ, input logic [7:0] tag);
        logic [BUSW-1:0] r;
        r = '0;
        r[BUSW-1:BWIDTH] = typ;
        r[39:32]         = tag;
        return r;
    endfunction

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state plus next values of every registered output and the captured context.
    always_comb begin
        stateNext = state;
        tagNext   = tagQ;
        idxNext   = idxQ;
        errNext   = errQ;
        rdNext    = rdQ;
        sVldNext  = SpSVLD;
        sBusNext  = SpSBUS;
        wrEn      = 1'b0;
        pulseNext = '0;

        case (state)
            IDLE: begin
                if (reqFire) begin
                    case (reqType)
                        TYP_RD_HDR: begin
                            tagNext   = reqTag;
                            idxNext   = reqIdx;
                            errNext   = reqBad;
                            rdNext    = 1'b1;
                            stateNext = RSP_HDR;
                            sVldNext  = 1'b1;
                            sBusNext  = mkRsp(reqBad ? RSP_ERR : RSP_OK, reqTag);
                        end
                        TYP_WR_HDR: begin
                            tagNext   = reqTag;
                            idxNext   = reqIdx;
                            errNext   = reqBad;
                            rdNext    = 1'b0;
                            stateNext = WDATA;
                        end
                        default: ;
                    endcase
                end
            end

            WDATA: begin
                if (reqFire) begin
                    case (reqType)
                        TYP_WR_DATA: begin
                            wrEn      = !errQ;
                            stateNext = RSP_HDR;
                            sVldNext  = 1'b1;
                            sBusNext  = mkRsp(errQ ? RSP_ERR : RSP_OK, tagQ);
                        end
                        TYP_RD_HDR, TYP_WR_HDR: begin
                            // A new header aborts the pending write; the abort is
                            // reported against the original write tag.
                            errNext   = 1'b1;
                            stateNext = RSP_HDR;
                            sVldNext  = 1'b1;
                            sBusNext  = mkRsp(RSP_ERR, tagQ);
                        end
                        default: ;
                    endcase
                end
            end

            RSP_HDR: begin
                if (rspFire) begin
                    if (rdQ && !errQ) begin
                        stateNext = RSP_DAT;
                        sBusNext  = {RSP_DATA, regs[idxQ]};
                    end else begin
                        stateNext = IDLE;
                        sVldNext  = 1'b0;
                        sBusNext  = '0;
                    end
                end
            end

            RSP_DAT: begin
                if (rspFire) begin
                    stateNext = IDLE;
                    sVldNext  = 1'b0;
                    sBusNext  = '0;
                end
            end

            default: begin
                stateNext = IDLE;
                sVldNext  = 1'b0;
                sBusNext  = '0;
            end
        endcase

        if (wrEn) begin
            pulseNext[idxQ] = 1'b1;
        end

        mRdyNext = (stateNext == IDLE) || (stateNext == WDATA);
    end

    // Registered bus outputs, write strobes and transaction context.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            SpMRDY   <= 1'b0;
            SpSVLD   <= 1'b0;
            SpSBUS   <= '0;
            WR_PULSE <= '0;
            tagQ     <= '0;
            idxQ     <= '0;
            errQ     <= 1'b0;
            rdQ      <= 1'b0;
        end else begin
            SpMRDY   <= mRdyNext;
            SpSVLD   <= sVldNext;
            SpSBUS   <= sBusNext;
            WR_PULSE <= pulseNext;
            tagQ     <= tagNext;
            idxQ     <= idxNext;
            errQ     <= errNext;
            rdQ      <= rdNext;
        end
    end

    // Register bank; the write lands on the same edge that raises SpSVLD.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wrEn) begin
            regs[idxQ] <= SpMBUS[BWIDTH-1:0];
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : gExport
        assign REG_OUT[g*BWIDTH +: BWIDTH] = regs[g];
    end

endmodule

// File: tb/tb_spartan_reg_slave.sv
// tb_spartan_reg_slave
// Table of directed transactions, hand-written multi-cycle sequences, and a
// randomized stream; all response beats are checked through an ordered queue.

module tb_spartan_reg_slave;

    localparam int BWIDTH = 64;
    localparam int NREGS  = 16;
    localparam int ADDR_LSB = 3;

    localparam logic [1:0] T_RD  = 2'b01;
    localparam logic [1:0] T_WRH = 2'b10;
    localparam logic [1:0] T_WRD = 2'b11;
    localparam logic [1:0] R_OK  = 2'b01;
    localparam logic [1:0] R_ERR = 2'b10;

    logic                     CLK;
    logic                     RST_N;
    logic [BWIDTH+1:0]        SpMBUS;
    logic                     SpMVLD;
    logic                     SpMRDY;
    logic [BWIDTH+1:0]        SpSBUS;
    logic                     SpSVLD;
    logic                     SpSRDY;
    logic [NREGS*BWIDTH-1:0]  REG_OUT;
    logic [NREGS-1:0]         WR_PULSE;

    int checks = 0;
    int failures = 0;
    logic [65:0] expQ[$];
    logic [63:0] modelRegs[NREGS];
    int pulseCnt = 0;
    logic [15:0] lastPulse = '0;
    bit rdyRandom = 0;

    typedef struct {
        bit          isWr;
        logic [7:0]  tag;
        logic [31:0] addr;
        logic [63:0] data;
        logic [1:0]  expRsp;
        bit          expHasData;
        logic [63:0] expData;
        logic [15:0] expPulse;
    } vecT;

    vecT vecs[13];

    spartan_reg_slave #(.BWIDTH(BWIDTH), .NREGS(NREGS), .ADDR_LSB(ADDR_LSB)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .SpMBUS(SpMBUS), .SpMVLD(SpMVLD), .SpMRDY(SpMRDY),
        .SpSBUS(SpSBUS), .SpSVLD(SpSVLD), .SpSRDY(SpSRDY),
        .REG_OUT(REG_OUT), .WR_PULSE(WR_PULSE)
    );

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "timeout");
    end

    function automatic logic [65:0] rspBeat(input logic [1:0] t, input logic [7:0] tag);
        logic [65:0] r;
        r = '0;
        r[65:64] = t;
        r[39:32] = tag;
        return r;
    endfunction

    function automatic logic [65:0] datBeat(input logic [63:0] d);
        return {2'b11, d};
    endfunction

    function automatic logic [63:0] hdr(input logic [7:0] tag, input logic [31:0] addr);
        return {24'h0, tag, addr};
    endfunction

    function automatic bit badAddr(input logic [31:0] a);
        return (a[2:0] != 3'd0) || (a >= 32'h80);
    endfunction

    function automatic vecT mkVec(input bit w, input logic [7:0] tag, input logic [31:0] addr,
                                  input logic [63:0] d, input logic [1:0] er, input bit hd,
                                  input logic [63:0] ed, input logic [15:0] ep);
        vecT v;
        v.isWr = w; v.tag = tag; v.addr = addr; v.data = d;
        v.expRsp = er; v.expHasData = hd; v.expData = ed; v.expPulse = ep;
        return v;
    endfunction

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkBank(input string name);
        int bad;
        bad = -1;
        for (int i = 0; i < NREGS; i++) begin
            if (bad < 0 && REG_OUT[i*64 +: 64] !== modelRegs[i]) bad = i;
        end
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s: reg%0d got %h, expected %h", name, bad, REG_OUT[bad*64 +: 64], modelRegs[bad]);
        end
    endtask

    // Response monitor / scoreboard and write-strobe tracker.
    initial begin
        forever begin
            @(negedge CLK);
            if (RST_N && SpSVLD && SpSRDY) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected: got %h, expected no beat", SpSBUS);
                end else begin
                    check("rsp_beat", SpSBUS, expQ.pop_front());
                end
            end
            if (RST_N && WR_PULSE != '0) begin
                pulseCnt++;
                lastPulse = WR_PULSE;
            end
        end
    end

    // Random response backpressure when enabled.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (rdyRandom) SpSRDY = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic sendBeat(input logic [1:0] typ, input logic [63:0] pay, input int gap);
        bit done;
        done = 0;
        repeat (gap) begin
            @(posedge CLK);
            #1;
        end
        SpMBUS = {typ, pay};
        SpMVLD = 1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge CLK);
            if (SpMRDY) done = 1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL req_accept_timeout: SpMRDY 0 for 200 cycles, expected 1");
        end
        @(posedge CLK);
        #1;
        SpMVLD = 0;
        SpMBUS = '0;
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge CLK);
            if (expQ.size() == 0 && !SpSVLD) ok = 1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d beats still pending, expected 0", expQ.size());
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic waitVld(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge CLK);
            if (SpSVLD) ok = 1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s: SpSVLD 0 for 50 cycles, expected 1", name);
        end
    endtask

    task automatic runVec(input vecT v);
        int p0;
        p0 = pulseCnt;
        expQ.push_back(rspBeat(v.expRsp, v.tag));
        if (v.expHasData) expQ.push_back(datBeat(v.expData));
        if (v.isWr) begin
            sendBeat(T_WRH, hdr(v.tag, v.addr), 0);
            sendBeat(T_WRD, v.data, 0);
        end else begin
            sendBeat(T_RD, hdr(v.tag, v.addr), 0);
        end
        drain();
        if (v.expPulse != '0) begin
            check("vec_pulse_count", 66'(pulseCnt - p0), 66'd1);
            check("vec_pulse_bit", 66'(lastPulse), 66'(v.expPulse));
            for (int i = 0; i < NREGS; i++) if (v.expPulse[i]) modelRegs[i] = v.data;
        end else begin
            check("vec_no_pulse", 66'(pulseCnt - p0), 66'd0);
        end
        checkBank("vec_reg_bank");
    endtask

    task automatic streamWrite(input logic [7:0] tag, input logic [31:0] addr, input logic [63:0] d);
        bit bad;
        bad = badAddr(addr);
        expQ.push_back(rspBeat(bad ? R_ERR : R_OK, tag));
        if (!bad) modelRegs[addr[6:3]] = d;
        sendBeat(T_WRH, hdr(tag, addr), $urandom_range(0, 2));
        sendBeat(T_WRD, d, $urandom_range(0, 2));
    endtask

    task automatic streamRead(input logic [7:0] tag, input logic [31:0] addr);
        bit bad;
        bad = badAddr(addr);
        expQ.push_back(rspBeat(bad ? R_ERR : R_OK, tag));
        if (!bad) expQ.push_back(datBeat(modelRegs[addr[6:3]]));
        sendBeat(T_RD, hdr(tag, addr), $urandom_range(0, 2));
    endtask

    function automatic logic [31:0] randAddr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return (32'($urandom_range(0, 15)) << 3) | 32'($urandom_range(1, 7));
        if (r == 1) return 32'h80 + (32'($urandom_range(0, 31)) << 3);
        return 32'($urandom_range(0, 15)) << 3;
    endfunction

    initial begin
        int p0;
        int goodWr;
        logic [31:0] a;
        bit sawVld;

        vecs[0]  = mkVec(1, 8'h05, 32'h18, 64'hDEAD, R_OK, 0, 64'h0, 16'h0008);
        vecs[1]  = mkVec(0, 8'h06, 32'h18, 64'h0, R_OK, 1, 64'hDEAD, 16'h0);
        vecs[2]  = mkVec(0, 8'h07, 32'h80, 64'h0, R_ERR, 0, 64'h0, 16'h0);
        vecs[3]  = mkVec(1, 8'h08, 32'h1C, 64'h1234, R_ERR, 0, 64'h0, 16'h0);
        vecs[4]  = mkVec(1, 8'h0A, 32'h00, 64'h0123456789ABCDEF, R_OK, 0, 64'h0, 16'h0001);
        vecs[5]  = mkVec(1, 8'h0B, 32'h78, 64'hFFFFFFFFFFFFFFFF, R_OK, 0, 64'h0, 16'h8000);
        vecs[6]  = mkVec(0, 8'h0C, 32'h78, 64'h0, R_OK, 1, 64'hFFFFFFFFFFFFFFFF, 16'h0);
        vecs[7]  = mkVec(0, 8'h0D, 32'h00, 64'h0, R_OK, 1, 64'h0123456789ABCDEF, 16'h0);
        vecs[8]  = mkVec(0, 8'h0E, 32'h1C, 64'h0, R_ERR, 0, 64'h0, 16'h0);
        vecs[9]  = mkVec(0, 8'h0F, 32'h20, 64'h0, R_OK, 1, 64'h0, 16'h0);
        vecs[10] = mkVec(1, 8'h10, 32'h100, 64'h5555, R_ERR, 0, 64'h0, 16'h0);
        vecs[11] = mkVec(0, 8'h11, 32'hFFFFFFF8, 64'h0, R_ERR, 0, 64'h0, 16'h0);
        vecs[12] = mkVec(0, 8'hFF, 32'h18, 64'h0, R_OK, 1, 64'hDEAD, 16'h0);

        for (int i = 0; i < NREGS; i++) modelRegs[i] = '0;
        RST_N = 0;
        SpMVLD = 0;
        SpMBUS = '0;
        SpSRDY = 0;

        // Reset state.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_mrdy", 66'(SpMRDY), 66'd0);
        check("rst_svld", 66'(SpSVLD), 66'd0);
        check("rst_sbus", SpSBUS, 66'd0);
        check("rst_pulse", 66'(WR_PULSE), 66'd0);
        checkBank("rst_reg_bank");
        #1 RST_N = 1;
        #1 check("rel_mrdy_before_clk", 66'(SpMRDY), 66'd0);
        @(posedge CLK);
        #1;
        check("rel_mrdy_after_clk", 66'(SpMRDY), 66'd1);
        SpSRDY = 1;

        // Directed table.
        for (int i = 0; i < 13; i++) runVec(vecs[i]);

        // Write is visible and strobed on the cycle SpSVLD rises.
        expQ.push_back(rspBeat(R_OK, 8'h40));
        sendBeat(T_WRH, hdr(8'h40, 32'h10), 0);
        sendBeat(T_WRD, 64'hA5A5, 0);
        check("wr_vis_svld", 66'(SpSVLD), 66'd1);
        check("wr_vis_pulse", 66'(WR_PULSE), 66'h4);
        check("wr_vis_reg", 66'(REG_OUT[2*64 +: 64]), 66'hA5A5);
        check("wr_vis_mrdy", 66'(SpMRDY), 66'd0);
        modelRegs[2] = 64'hA5A5;
        drain();

        // Reserved beat inside WDATA is ignored.
        expQ.push_back(rspBeat(R_OK, 8'h50));
        sendBeat(T_WRH, hdr(8'h50, 32'h28), 0);
        sendBeat(2'b00, 64'h9999, 1);
        sendBeat(T_WRD, 64'h77, 0);
        modelRegs[5] = 64'h77;
        drain();
        checkBank("wdata_rsvd_bank");

        // Stray WR_DATA in IDLE is dropped silently.
        p0 = pulseCnt;
        sendBeat(T_WRD, 64'hBAD, 0);
        sawVld = 0;
        repeat (6) begin
            @(negedge CLK);
            if (SpSVLD) sawVld = 1;
        end
        check("stray_no_rsp", 66'(sawVld), 66'd0);
        check("stray_no_pulse", 66'(pulseCnt - p0), 66'd0);
        checkBank("stray_bank");
        @(posedge CLK);
        #1;

        // RD_HDR during WDATA aborts the write with its own tag.
        p0 = pulseCnt;
        expQ.push_back(rspBeat(R_ERR, 8'h09));
        sendBeat(T_WRH, hdr(8'h09, 32'h20), 0);
        sendBeat(T_RD, hdr(8'h33, 32'h08), 0);
        drain();
        check("abort_rd_no_pulse", 66'(pulseCnt - p0), 66'd0);
        check("abort_rd_idle", 66'(SpMRDY), 66'd1);
        checkBank("abort_rd_bank");

        // WR_HDR during WDATA aborts likewise.
        expQ.push_back(rspBeat(R_ERR, 8'h44));
        sendBeat(T_WRH, hdr(8'h44, 32'h30), 0);
        sendBeat(T_WRH, hdr(8'h45, 32'h38), 0);
        drain();
        check("abort_wr_no_pulse", 66'(pulseCnt - p0), 66'd0);
        checkBank("abort_wr_bank");

        // Backpressure on both response beats.
        SpSRDY = 0;
        expQ.push_back(rspBeat(R_OK, 8'h60));
        expQ.push_back(datBeat(64'hDEAD));
        sendBeat(T_RD, hdr(8'h60, 32'h18), 0);
        waitVld("bp_hdr_wait");
        for (int i = 0; i < 10; i++) begin
            check("bp_hdr_svld", 66'(SpSVLD), 66'd1);
            check("bp_hdr_sbus", SpSBUS, rspBeat(R_OK, 8'h60));
            check("bp_hdr_mrdy", 66'(SpMRDY), 66'd0);
            @(negedge CLK);
        end
        @(posedge CLK);
        #1 SpSRDY = 1;
        @(posedge CLK);
        #1 SpSRDY = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("bp_dat_svld", 66'(SpSVLD), 66'd1);
            check("bp_dat_sbus", SpSBUS, datBeat(64'hDEAD));
            check("bp_dat_mrdy", 66'(SpMRDY), 66'd0);
        end
        @(posedge CLK);
        #1 SpSRDY = 1;
        drain();

        // Randomized stream of write/read pairs.
        p0 = pulseCnt;
        goodWr = 0;
        rdyRandom = 1;
        for (int i = 0; i < 20; i++) begin
            a = randAddr();
            if (!badAddr(a)) goodWr++;
            streamWrite(8'(2 * i), a, {$urandom(), $urandom()});
            streamRead(8'(2 * i + 1), ($urandom_range(0, 1) == 1) ? a : randAddr());
        end
        drain();
        rdyRandom = 0;
        @(negedge CLK);
        #2 SpSRDY = 1;
        @(posedge CLK);
        #1;
        check("stream_pulse_count", 66'(pulseCnt - p0), 66'(goodWr));
        checkBank("stream_bank");

        // Reset while a data beat is being presented.
        modelRegs[3] = 64'hC0FFEE;
        expQ.push_back(rspBeat(R_OK, 8'h61));
        sendBeat(T_WRH, hdr(8'h61, 32'h18), 0);
        sendBeat(T_WRD, 64'hC0FFEE, 0);
        drain();
        SpSRDY = 0;
        expQ.push_back(rspBeat(R_OK, 8'h62));
        expQ.push_back(datBeat(64'hC0FFEE));
        sendBeat(T_RD, hdr(8'h62, 32'h18), 0);
        waitVld("rstmid_wait");
        @(posedge CLK);
        #1 SpSRDY = 1;
        @(posedge CLK);
        #1 SpSRDY = 0;
        check("rstmid_dat_phase", 66'(SpSBUS[65:64]), 66'(2'b11));
        #2 RST_N = 0;
        #1;
        check("rstmid_svld", 66'(SpSVLD), 66'd0);
        check("rstmid_mrdy", 66'(SpMRDY), 66'd0);
        expQ.delete();
        for (int i = 0; i < NREGS; i++) modelRegs[i] = '0;
        checkBank("rstmid_bank");
        @(negedge CLK);
        #1 RST_N = 1;
        #1 check("rstmid_mrdy_before_clk", 66'(SpMRDY), 66'd0);
        @(posedge CLK);
        #1;
        check("rstmid_mrdy_after_clk", 66'(SpMRDY), 66'd1);
        SpSRDY = 1;
        expQ.push_back(rspBeat(R_OK, 8'h70));
        expQ.push_back(datBeat(64'h0));
        sendBeat(T_RD, hdr(8'h70, 32'h18), 0);
        drain();

        check("queue_empty", 66'(expQ.size()), 66'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
